// File: rtl/traffic_phase_scheduler_if.sv
// Junction-side signal bundle for traffic_phase_scheduler: timing strobe, vehicle requests,
// lamp heads and status. EMERGENCY_PREEMPT_EN adds the emg_req/emg_sel preemption pair.
interface traffic_phase_scheduler_if;
  logic       tick_en;
  logic [3:0] req;
`ifdef EMERGENCY_PREEMPT_EN
  logic       emg_req;
  logic [1:0] emg_sel;
`endif
  logic [2:0] T1;
  logic [2:0] T2;
  logic [2:0] S1;
  logic [2:0] S2;
  logic [3:0] grant;
  logic       busy;

`ifdef EMERGENCY_PREEMPT_EN
  modport master (
    output tick_en, req, emg_req, emg_sel,
    input  T1, T2, S1, S2, grant, busy
  );
  modport slave (
    input  tick_en, req, emg_req, emg_sel,
    output T1, T2, S1, S2, grant, busy
  );
`else
  modport master (
    output tick_en, req,
    input  T1, T2, S1, S2, grant, busy
  );
  modport slave (
    input  tick_en, req,
    output T1, T2, S1, S2, grant, busy
  );
`endif
endinterface

// File: rtl/traffic_phase_scheduler.sv
// Demand-driven round-robin phase scheduler for a 4-approach junction (GREEN->YELLOW->ALLRED).
// Optional emergency preemption is compiled in with EMERGENCY_PREEMPT_EN.
module traffic_phase_scheduler #(
  parameter int GREEN_MIN = 7,
  parameter int GREEN_MAX = 20,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 2,
  parameter int CNT_W     = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  traffic_phase_scheduler_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GREEN  = 3'd1,
    ST_YELLOW = 3'd2,
    ST_ALLRED = 3'd3
  } state_t;

  localparam logic [CNT_W-1:0] GMIN_C  = CNT_W'(GREEN_MIN);
  localparam logic [CNT_W-1:0] GMAX_C  = CNT_W'(GREEN_MAX);
  localparam logic [CNT_W-1:0] YEND_C  = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] AEND_C  = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};
  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]       pending_q, pending_d, pend_all, others;
  logic [1:0]       last_q, last_d;
  logic [1:0]       cur_q, cur_d;
  logic [3:0]       grant_q, grant_d;
  logic             busy_q, busy_d;
  logic             go_yellow;
  logic             emg_active;
  logic [1:0]       emg_target;

  // First set bit of pend searching upward from base+1, wrapping mod 4.
  function automatic logic [1:0] rr_pick(input logic [3:0] pend, input logic [1:0] base);
    logic [1:0] idx;
    logic       found;
    rr_pick = base + 2'd1;
    found   = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = base + k[1:0];
      if (!found && pend[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

`ifdef EMERGENCY_PREEMPT_EN
  logic       emg_req_q;
  logic [1:0] emg_sel_q;

  // The selected approach is captured on the rising edge of emg_req and held after that.
  assign emg_active = bus.emg_req;
  assign emg_target = (bus.emg_req && !emg_req_q) ? bus.emg_sel : emg_sel_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      emg_req_q <= 1'b0;
      emg_sel_q <= 2'd0;
    end else begin
      emg_req_q <= bus.emg_req;
      emg_sel_q <= emg_target;
    end
  end
`else
  assign emg_active = 1'b0;
  assign emg_target = 2'd0;
`endif

  assign pend_all = pending_q | bus.req;
  assign others   = pend_all & ~(4'b0001 << cur_q);
  assign cnt_inc  = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pending_q <= '0;
      last_q    <= 2'd3;
      cur_q     <= 2'd0;
      grant_q   <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      last_q    <= last_d;
      cur_q     <= cur_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin : next_state
    state_d   = state_q;
    cnt_d     = cnt_q;
    pending_d = pend_all;
    last_d    = last_q;
    cur_d     = cur_q;
    go_yellow = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (emg_active) begin
          state_d = ST_GREEN;
          cur_d   = emg_target;
        end else if (|pend_all) begin
          state_d = ST_GREEN;
          cur_d   = rr_pick(pend_all, last_q);
        end
      end
      ST_GREEN: begin
        if (emg_active) begin
          go_yellow = (cur_q != emg_target);
        end else begin
          go_yellow = (cnt_q >= GMIN_C) && (|others) &&
                      (!bus.req[cur_q] || (cnt_q >= GMAX_C));
        end
        if (go_yellow) begin
          state_d = ST_YELLOW;
        end else if (bus.tick_en) begin
          cnt_d = cnt_inc;
        end
      end
      ST_YELLOW: begin
        if (bus.tick_en) begin
          if (cnt_q == YEND_C) begin
            state_d = ST_ALLRED;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      ST_ALLRED: begin
        if (bus.tick_en) begin
          if (cnt_q == AEND_C) begin
            // The approach just cleared becomes the round-robin base for this pick.
            last_d = cur_q;
            if (emg_active) begin
              state_d = ST_GREEN;
              cur_d   = emg_target;
            end else if (|pend_all) begin
              state_d = ST_GREEN;
              cur_d   = rr_pick(pend_all, cur_q);
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d != state_q) begin
      cnt_d = '0;
    end
    // Entering green consumes the request, including any req seen on the entry cycle.
    if ((state_d == ST_GREEN) && (state_q != ST_GREEN)) begin
      pending_d[cur_d] = 1'b0;
    end
  end

  always_comb begin : outputs
    grant_d = '0;
    busy_d  = (state_d != ST_IDLE);
    if ((state_d == ST_GREEN) || (state_d == ST_YELLOW)) begin
      grant_d[cur_d] = 1'b1;
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_lamp
    logic [2:0] lamp_d;
    logic [2:0] lamp_q;

    assign lamp_d = !grant_d[gi]              ? LAMP_RED :
                    (state_d == ST_YELLOW)    ? LAMP_YEL : LAMP_GRN;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        lamp_q <= LAMP_RED;
      end else begin
        lamp_q <= lamp_d;
      end
    end
  end

  assign bus.T1    = g_lamp[0].lamp_q;
  assign bus.T2    = g_lamp[1].lamp_q;
  assign bus.S1    = g_lamp[2].lamp_q;
  assign bus.S2    = g_lamp[3].lamp_q;
  assign bus.grant = grant_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Self-checking bench for traffic_phase_scheduler: vector table, hand-written corner sequences
// and randomized traffic checked against a phase-level reference model.
module tb_traffic_phase_scheduler;

  localparam int GMIN = 7;
  localparam int GMAX = 20;
  localparam int YT   = 3;
  localparam int ART  = 2;
  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  traffic_phase_scheduler_if bus ();

  traffic_phase_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [16:0] out_pack;
  assign out_pack = {bus.T1, bus.T2, bus.S1, bus.S2, bus.grant, bus.busy};

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    string      name;
    bit         rst_n;
    logic [3:0] req;
    bit         tick;
    int         reps;
    logic [16:0] exp;
  } vec_t;
  vec_t tbl[$];

  // Reference model: phase 0 idle, 1 green, 2 yellow, 3 all-red; ticks elapsed in the phase.
  int         m_ph, m_el, m_cur, m_last;
  logic [3:0] m_pend;

  function automatic logic [16:0] mk(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c,
                                     input logic [2:0] d, input logic [3:0] g, input logic bz);
    return {a, b, c, d, g, bz};
  endfunction

  function automatic int next_rr(input logic [3:0] p, input int base);
    for (int k = 1; k <= 4; k++) begin
      if (p[(base + k) % 4]) return (base + k) % 4;
    end
    return -1;
  endfunction

  task automatic enter_green(input logic [3:0] pe, input int who);
    m_ph   = 1;
    m_el   = 0;
    m_cur  = who;
    m_pend = pe;
    m_pend[who] = 1'b0;
  endtask

  task automatic model_step(input bit rn, input logic [3:0] r, input bit t);
    logic [3:0] pe;
    logic [3:0] oth;
    if (!rn) begin
      m_ph = 0; m_el = 0; m_cur = 0; m_last = 3; m_pend = '0;
      return;
    end
    pe  = m_pend | r;
    oth = pe;
    oth[m_cur] = 1'b0;
    m_pend = pe;
    case (m_ph)
      0: if (pe != 0) enter_green(pe, next_rr(pe, m_last));
      1: begin
        if (m_el >= GMIN && oth != 0 && (!r[m_cur] || m_el >= GMAX)) begin
          m_ph = 2; m_el = 0;
        end else if (t) begin
          m_el++;
        end
      end
      2: if (t) begin
        m_el++;
        if (m_el == YT) begin m_ph = 3; m_el = 0; end
      end
      default: if (t) begin
        m_el++;
        if (m_el == ART) begin
          m_last = m_cur;
          if (pe != 0) enter_green(pe, next_rr(pe, m_cur));
          else begin m_ph = 0; m_el = 0; end
        end
      end
    endcase
  endtask

  function automatic logic [16:0] model_exp();
    logic [2:0] l [4];
    logic [3:0] g;
    g = '0;
    for (int i = 0; i < 4; i++) l[i] = R;
    if (m_ph == 1 || m_ph == 2) begin
      g[m_cur] = 1'b1;
      l[m_cur] = (m_ph == 1) ? G : Y;
    end
    return {l[0], l[1], l[2], l[3], g, (m_ph != 0)};
  endfunction

  function automatic int grant_idx(input logic [3:0] g);
    for (int i = 0; i < 4; i++) begin
      if (g == (4'b0001 << i)) return i;
    end
    return -1;
  endfunction

  function automatic int classify(input logic [16:0] o);
    int idx;
    logic [2:0] l;
    if (!o[0]) return 0;
    idx = grant_idx(o[4:1]);
    if (idx < 0) return (o[4:1] == 4'd0) ? 3 : 4;
    l = o[16 - 3*idx -: 3];
    if (l == G) return 1;
    if (l == Y) return 2;
    return 4;
  endfunction

  task automatic check(input string nm, input logic [16:0] exp);
    n_vec++;
    if (out_pack !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, out_pack, exp);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] r, input bit t);
    bus.req = r;
    bus.tick_en = t;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.req = '0;
    bus.tick_en = 1'b0;
    model_step(1'b0, 4'h0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic add(input string nm, input bit rn, input logic [3:0] r, input bit t,
                     input int reps, input logic [16:0] exp);
    vec_t v;
    v.name = nm; v.rst_n = rn; v.req = r; v.tick = t; v.reps = reps; v.exp = exp;
    tbl.push_back(v);
  endtask

  logic [3:0] rq;
  bit         tk, rn;
  int         ng, last_ph, cur_ph, ph_ticks, cyc;
  int         exp_order [4];

  initial begin
    bus.req = '0;
    bus.tick_en = 1'b0;
`ifdef EMERGENCY_PREEMPT_EN
    bus.emg_req = 1'b0;
    bus.emg_sel = 2'd0;
`endif
    exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 3; exp_order[3] = 0;

    add("rst_hold",      0, 4'hF,    1, 10, mk(R, R, R, R, 4'b0000, 0));
    add("rst_rel_idle",  1, 4'h0,    1, 3,  mk(R, R, R, R, 4'b0000, 0));
    add("s1_grant",      1, 4'b0100, 0, 1,  mk(R, R, G, R, 4'b0100, 1));
    add("s1_green",      1, 4'h0,    1, 1,  mk(R, R, G, R, 4'b0100, 1));
    add("t1_req",        1, 4'b0001, 0, 1,  mk(R, R, G, R, 4'b0100, 1));
    add("s1_to_min",     1, 4'h0,    1, 6,  mk(R, R, G, R, 4'b0100, 1));
    add("s1_gap_yellow", 1, 4'h0,    0, 1,  mk(R, R, Y, R, 4'b0100, 1));
    add("s1_yellow",     1, 4'h0,    1, 2,  mk(R, R, Y, R, 4'b0100, 1));
    add("s1_allred",     1, 4'h0,    1, 2,  mk(R, R, R, R, 4'b0000, 1));
    add("t1_grant",      1, 4'h0,    1, 1,  mk(G, R, R, R, 4'b0001, 1));
    add("t1_rest",       1, 4'h0,    1, 5,  mk(G, R, R, R, 4'b0001, 1));
    add("t1_held",       1, 4'b0011, 1, 15, mk(G, R, R, R, 4'b0001, 1));
    add("t1_max_yellow", 1, 4'b0011, 0, 1,  mk(Y, R, R, R, 4'b0001, 1));
    add("t1_yellow",     1, 4'b0011, 1, 2,  mk(Y, R, R, R, 4'b0001, 1));
    add("t1_allred",     1, 4'b0011, 1, 2,  mk(R, R, R, R, 4'b0000, 1));
    add("t2_grant",      1, 4'b0011, 1, 1,  mk(R, G, R, R, 4'b0010, 1));

    @(negedge clk);
    foreach (tbl[i]) begin
      for (int r = 0; r < tbl[i].reps; r++) begin
        rst = tbl[i].rst_n;
        bus.req = tbl[i].req;
        bus.tick_en = tbl[i].tick;
        @(posedge clk);
        @(negedge clk);
        check(tbl[i].name, tbl[i].exp);
      end
      $display("vec %0d %s rst=%b req=%b tick=%b x%0d out=%h", i, tbl[i].name, tbl[i].rst_n,
               tbl[i].req, tbl[i].tick, tbl[i].reps, out_pack);
    end

    // Single request rests on green past counter saturation, then yields on a gap.
    do_reset();
    drive(4'b0100, 0);
    check("single_grant", mk(R, R, G, R, 4'b0100, 1));
    for (int k = 1; k <= 260; k++) begin
      drive(4'h0, 1);
      if (k % 50 == 0) check("single_rest", mk(R, R, G, R, 4'b0100, 1));
    end
    drive(4'b0001, 0);
    check("rest_yield", mk(R, R, Y, R, 4'b0100, 1));
    $display("seq single_rest done out=%h", out_pack);

    // Gap-out at GREEN_MIN, then reset in the middle of yellow.
    do_reset();
    drive(4'b0001, 0);
    check("gap_t1_grant", mk(G, R, R, R, 4'b0001, 1));
    for (int k = 0; k < 3; k++) drive(4'b0011, 1);
    for (int k = 0; k < 4; k++) drive(4'b0010, 1);
    check("gap_at_min", mk(G, R, R, R, 4'b0001, 1));
    drive(4'b0010, 0);
    check("gap_yellow", mk(Y, R, R, R, 4'b0001, 1));
    drive(4'b0010, 1);
    check("gap_yellow_cnt1", mk(Y, R, R, R, 4'b0001, 1));
    rst = 1'b0;
    bus.req = '0;
    #1;
    check("rst_mid_yellow", mk(R, R, R, R, 4'b0000, 0));
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 5; k++) drive(4'h0, 1);
    check("post_rst_idle", mk(R, R, R, R, 4'b0000, 0));
    drive(4'b1000, 0);
    check("post_rst_s2", mk(R, R, R, G, 4'b1000, 1));
    $display("seq gap_and_reset done out=%h", out_pack);

    // Round-robin with three held requests, tick every fourth clock.
    do_reset();
    bus.req = 4'b1011;
    ng = 0; last_ph = 0; ph_ticks = 0; cyc = 0;
    while (ng < 4 && cyc < 3000) begin
      cur_ph = classify(out_pack);
      if (cur_ph != last_ph) begin
        if (ng >= 1 && ng <= 3) begin
          if (last_ph == 1) check_int("rr_green_ticks", ph_ticks, GMAX);
          if (last_ph == 2) check_int("rr_yellow_ticks", ph_ticks, YT);
          if (last_ph == 3) check_int("rr_allred_ticks", ph_ticks, ART);
        end
        if (cur_ph == 1) begin
          check_int("rr_order", grant_idx(out_pack[4:1]), exp_order[ng]);
          $display("rr green #%0d on approach %0d at cycle %0d", ng, grant_idx(out_pack[4:1]), cyc);
          ng++;
        end
        ph_ticks = 0;
        last_ph = cur_ph;
      end
      tk = (cyc % 4 == 0);
      bus.tick_en = tk;
      if (tk) ph_ticks++;
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    if (ng < 4) check_int("rr_timeout_greens", ng, 4);

`ifdef EMERGENCY_PREEMPT_EN
    do_reset();
    drive(4'b0001, 0);
    drive(4'h0, 1);
    drive(4'h0, 1);
    bus.emg_req = 1'b1;
    bus.emg_sel = 2'd3;
    drive(4'h0, 0);
    check("emg_yellow", mk(Y, R, R, R, 4'b0001, 1));
    bus.emg_sel = 2'd1;
    for (int k = 0; k < YT; k++) drive(4'h0, 1);
    check("emg_allred", mk(R, R, R, R, 4'b0000, 1));
    for (int k = 0; k < ART; k++) drive(4'h0, 1);
    check("emg_s2_green", mk(R, R, R, G, 4'b1000, 1));
    for (int k = 0; k < 40; k++) drive(4'b0001, 1);
    check("emg_s2_hold", mk(R, R, R, G, 4'b1000, 1));
    bus.emg_req = 1'b0;
    do_reset();
`endif

    // Randomized traffic against the reference model.
    do_reset();
    rq = '0;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 39) == 0) rq[$urandom_range(0, 3)] = ~rq[$urandom_range(0, 3)];
      if ($urandom_range(0, 29) == 0) rq = 4'($urandom_range(0, 15));
      tk = ($urandom_range(0, 2) == 0);
      rn = ($urandom_range(0, 799) != 0);
      rst = rn;
      bus.req = rq;
      bus.tick_en = tk;
      model_step(rn, rq, tk);
      @(posedge clk);
      @(negedge clk);
      check("rand", model_exp());
    end
    $display("seq random done out=%h", out_pack);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
